pwr_clock_gate_ctrl: RTL and testbench

- Controller that drives the enable input of a latch-based clock gate cell; it is the producer side of the cell's `enable` interface.
- Watches activity of the gated domain, counts idle cycles, drains, then deasserts `cg_enable`.
- Re-enables the clock on wake request, activity or override, and acknowledges once the gated domain clock is stable.
- Sits in the ungated `clk` domain next to the clock gate cell.

---
 rtl/pwr_cg_pkg.sv | 24 ++
 rtl/pwr_cg_sat_counter.sv | 19 +
 rtl/pwr_clock_gate_ctrl.sv | 116 +++++++++++
 tb/tb_pwr_clock_gate_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pwr_cg_pkg.sv
// rtl/pwr_cg_pkg.sv - shared types, defaults and counter sizing for the clock gate controller
package pwr_cg_pkg;

  typedef enum logic [1:0] {
    CG_RUN   = 2'd0,
    CG_DRAIN = 2'd1,
    CG_GATED = 2'd2,
    CG_WAKE  = 2'd3
  } cg_state_e;

  localparam int DEF_IDLE_CYCLES  = 16;
  localparam int DEF_DRAIN_CYCLES = 2;
  localparam int DEF_WAKE_CYCLES  = 2;

  // Wide enough for the largest cycle count plus headroom so no counter can wrap.
  function automatic int cg_cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/pwr_cg_sat_counter.sv
// rtl/pwr_cg_sat_counter.sv - saturating up-counter with synchronous clear
module pwr_cg_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pwr_clock_gate_ctrl.sv
// rtl/pwr_clock_gate_ctrl.sv - idle-detect / drain / wake controller for a latch-based clock gate
// Optional statistics counters enabled by defining PWR_CG_STATS_EN.
module pwr_clock_gate_ctrl
  import pwr_cg_pkg::*;
#(
  parameter int IDLE_CYCLES  = DEF_IDLE_CYCLES,
  parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES,
  parameter int WAKE_CYCLES  = DEF_WAKE_CYCLES,
  parameter int STAT_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              busy,
  input  logic              wake_req,
  input  logic              force_on,
  output logic              cg_enable,
  output logic              gated,
  output logic              wake_ack,
  output logic [STAT_W-1:0] gated_cycles,
  output logic [STAT_W-1:0] gate_events
);

  localparam int CW = cg_cnt_width(IDLE_CYCLES, DRAIN_CYCLES, WAKE_CYCLES);

  cg_state_e     state, state_nx;
  logic [CW-1:0] idle_cnt;
  logic [CW-1:0] drain_cnt, drain_cnt_nx;
  logic [CW-1:0] wake_cnt, wake_cnt_nx;
  logic          idle;
  logic          idle_clr;

  assign idle = !busy && !wake_req && !force_on;

  // Idle streak only survives while staying in CG_RUN with idle inputs.
  assign idle_clr = rst || (state != CG_RUN) || !idle || (state_nx != CG_RUN);

  pwr_cg_sat_counter #(.W(CW)) u_idle_cnt (
    .clk   (clk),
    .clr   (idle_clr),
    .inc   (1'b1),
    .count (idle_cnt)
  );

  always_comb begin
    state_nx     = state;
    drain_cnt_nx = '0;
    wake_cnt_nx  = '0;
    case (state)
      CG_RUN: begin
        if (idle && (idle_cnt == CW'(IDLE_CYCLES - 1))) state_nx = CG_DRAIN;
      end
      CG_DRAIN: begin
        if (!idle) begin
          state_nx = CG_RUN;
        end else if (drain_cnt == CW'(DRAIN_CYCLES - 1)) begin
          state_nx = CG_GATED;
        end else begin
          drain_cnt_nx = drain_cnt + 1'b1;
        end
      end
      CG_GATED: begin
        if (!idle) state_nx = CG_WAKE;
      end
      CG_WAKE: begin
        // Inputs are ignored here; the wake period always runs to completion.
        if (wake_cnt == CW'(WAKE_CYCLES - 1)) begin
          state_nx = CG_RUN;
        end else begin
          wake_cnt_nx = wake_cnt + 1'b1;
        end
      end
      default: state_nx = CG_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CG_RUN;
      drain_cnt <= '0;
      wake_cnt  <= '0;
      cg_enable <= 1'b1;
      gated     <= 1'b0;
      wake_ack  <= 1'b0;
    end else begin
      state     <= state_nx;
      drain_cnt <= drain_cnt_nx;
      wake_cnt  <= wake_cnt_nx;
      cg_enable <= (state_nx != CG_GATED);
      gated     <= (state_nx == CG_GATED);
      wake_ack  <= (state == CG_WAKE) && (state_nx == CG_RUN);
    end
  end

`ifdef PWR_CG_STATS_EN
  logic gate_evt;
  assign gate_evt = (state == CG_DRAIN) && (state_nx == CG_GATED);

  pwr_cg_sat_counter #(.W(STAT_W)) u_gated_cycles (
    .clk   (clk),
    .clr   (rst),
    .inc   (gated),
    .count (gated_cycles)
  );

  pwr_cg_sat_counter #(.W(STAT_W)) u_gate_events (
    .clk   (clk),
    .clr   (rst),
    .inc   (gate_evt),
    .count (gate_events)
  );
`else
  assign gated_cycles = '0;
  assign gate_events  = '0;
`endif

endmodule

// File: tb/tb_pwr_clock_gate_ctrl.sv
// tb/tb_pwr_clock_gate_ctrl.sv - self-checking bench for pwr_clock_gate_ctrl (PWR_CG_STATS_EN aware)
module tb_pwr_clock_gate_ctrl;

  localparam int IDLE   = 4;
  localparam int DRAIN  = 2;
  localparam int WAKE   = 3;
  localparam int STAT_W = 32;
`ifdef PWR_CG_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy = 1'b0;
  logic wake_req = 1'b0;
  logic force_on = 1'b0;
  logic cg_enable, gated, wake_ack;
  logic [STAT_W-1:0] gated_cycles, gate_events;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  pwr_clock_gate_ctrl #(
    .IDLE_CYCLES  (IDLE),
    .DRAIN_CYCLES (DRAIN),
    .WAKE_CYCLES  (WAKE),
    .STAT_W       (STAT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .busy         (busy),
    .wake_req     (wake_req),
    .force_on     (force_on),
    .cg_enable    (cg_enable),
    .gated        (gated),
    .wake_ack     (wake_ack),
    .gated_cycles (gated_cycles),
    .gate_events  (gate_events)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the clock gates after IDLE+DRAIN consecutive idle cycles while ungated;
  // any non-idle input while gated starts a fixed WAKE-cycle wake ending in an ack.
  int      streak    = 0;
  int      wake_left = 0;
  bit      m_gated   = 1'b0;
  bit      m_ack     = 1'b0;
  longint  m_gcyc    = 0;
  longint  m_gev     = 0;
  bit      idl;

  always @(posedge clk) begin
    if (rst) begin
      streak = 0; wake_left = 0; m_gated = 1'b0; m_ack = 1'b0; m_gcyc = 0; m_gev = 0;
    end else begin
      idl = !busy && !wake_req && !force_on;
      if (m_gated) m_gcyc++;
      m_ack = 1'b0;
      if (wake_left > 0) begin
        wake_left--;
        if (wake_left == 0) m_ack = 1'b1;
      end else if (m_gated) begin
        if (!idl) begin
          m_gated   = 1'b0;
          wake_left = WAKE;
        end
      end else begin
        streak = idl ? streak + 1 : 0;
        if (streak == IDLE + DRAIN) begin
          m_gated = 1'b1;
          streak  = 0;
          m_gev++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cg_enable", 64'(cg_enable), 64'(!m_gated));
      chk("gated", 64'(gated), 64'(m_gated));
      chk("wake_ack", 64'(wake_ack), 64'(m_ack));
      chk("gated_cycles", 64'(gated_cycles), STATS ? 64'(m_gcyc) : 64'd0);
      chk("gate_events", 64'(gate_events), STATS ? 64'(m_gev) : 64'd0);
    end
  end

  // Leaves the caller at cycle 0: first cycle with rst low, outputs in reset state.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; busy = 1'b0; wake_req = 1'b0; force_on = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  int drops;
  int acks;
  int hold;

  initial begin
    // Basic gating latency and reset state
    do_reset();
    chk("rst_cg_enable", 64'(cg_enable), 64'd1);
    chk("rst_gated", 64'(gated), 64'd0);
    chk("rst_wake_ack", 64'(wake_ack), 64'd0);
    chk("rst_gate_events", 64'(gate_events), 64'd0);
    step(5);
    chk("t1_c5_cg_enable", 64'(cg_enable), 64'd1);
    step(1);
    chk("t1_c6_cg_enable", 64'(cg_enable), 64'd0);
    chk("t1_c6_gated", 64'(gated), 64'd1);
    chk("t1_c6_gate_events", 64'(gate_events), STATS ? 64'd1 : 64'd0);
    chk("t1_model_gated", 64'(m_gated), 64'd1);

    // Wake request at cycle 8, ack at cycle 12
    step(2);
    wake_req = 1'b1;
    step(1);
    chk("t2_t1_cg_enable", 64'(cg_enable), 64'd1);
    chk("t2_t1_gated", 64'(gated), 64'd0);
    chk("t2_gated_cycles", 64'(gated_cycles), STATS ? 64'd3 : 64'd0);
    acks = 0;
    for (int k = 0; k < 2; k++) begin
      step(1);
      acks += int'(wake_ack);
    end
    chk("t2_no_early_ack", 64'(acks), 64'd0);
    step(1);
    chk("t2_t4_wake_ack", 64'(wake_ack), 64'd1);
    chk("t2_model_ack", 64'(m_ack), 64'd1);
    wake_req = 1'b0;
    step(1);
    chk("t2_t5_wake_ack", 64'(wake_ack), 64'd0);

    // busy in the last drain cycle aborts gating
    do_reset();
    step(5);
    busy = 1'b1;
    step(1);
    busy = 1'b0;
    drops = 0;
    for (int k = 6; k < 12; k++) begin
      drops += int'(!cg_enable);
      if (k == 11) chk("t3_events_before", 64'(gate_events), 64'd0);
      step(1);
    end
    chk("t3_no_drop", 64'(drops), 64'd0);
    chk("t3_c12_cg_enable", 64'(cg_enable), 64'd0);
    chk("t3_c12_gate_events", 64'(gate_events), STATS ? 64'd1 : 64'd0);

    // force_on holds the clock on; gating follows IDLE+DRAIN after release
    do_reset();
    force_on = 1'b1;
    drops = 0;
    for (int k = 0; k < 100; k++) begin
      drops += int'(!cg_enable);
      step(1);
    end
    force_on = 1'b0;
    chk("t4_force_no_drop", 64'(drops), 64'd0);
    step(5);
    chk("t4_r5_cg_enable", 64'(cg_enable), 64'd1);
    step(1);
    chk("t4_r6_cg_enable", 64'(cg_enable), 64'd0);

    // Reset in the middle of a wake drops the pending ack
    do_reset();
    step(7);
    wake_req = 1'b1;
    step(1);
    chk("t5_wake_cg_enable", 64'(cg_enable), 64'd1);
    rst = 1'b1;
    step(1);
    chk("t5_rst_cg_enable", 64'(cg_enable), 64'd1);
    chk("t5_rst_gated", 64'(gated), 64'd0);
    chk("t5_rst_wake_ack", 64'(wake_ack), 64'd0);
    chk("t5_rst_gated_cycles", 64'(gated_cycles), 64'd0);
    chk("t5_rst_gate_events", 64'(gate_events), 64'd0);
    rst = 1'b0;
    wake_req = 1'b0;
    acks = 0;
    for (int k = 0; k < 6; k++) begin
      step(1);
      acks += int'(wake_ack);
    end
    chk("t5_no_ack_after_rst", 64'(acks), 64'd0);

    // Randomized traffic against the reference model
    do_reset();
    hold = 0;
    for (int i = 0; i < 4000; i++) begin
      step(1);
      if (wake_req) begin
        if (wake_ack) begin
          wake_req = 1'b0;
        end else begin
          hold++;
          if (hold > WAKE + 4) begin
            chk("rand_wake_ack_timeout", 64'(hold), 64'(WAKE + 1));
            wake_req = 1'b0;
          end
        end
      end else if (gated && ($urandom_range(0, 3) == 0)) begin
        wake_req = 1'b1;
        hold = 0;
      end
      busy     = ($urandom_range(0, 9) == 0);
      force_on = ($urandom_range(0, 59) == 0);
      rst      = ($urandom_range(0, 399) == 0);
      if (rst) wake_req = 1'b0;
    end
    step(1);
    rst = 1'b0; busy = 1'b0; force_on = 1'b0; wake_req = 1'b0;
    step(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
